// File: rtl/axi_cmd_arbiter_pkg.sv
// Shared types and constants for the AXI command arbiter slice.
// Contents: FSM state enum, AXI response codes, burst geometry constants,
// and a helper that sizes requester-index fields.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned BEAT_BYTES     = 4;
    localparam int unsigned BOUNDARY_BYTES = 4096;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_cmd_arbiter_if.sv
// Bundle of requester-side and engine-side handshake signals for the
// AXI command arbiter.
//   slave  : arbiter view (takes requests, drives responses and engine cmd)
//   master : client/engine view (drives requests, cmd_ready, done)
interface axi_cmd_arbiter_if
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 8
);
    localparam int unsigned ID_W = id_width(NUM_REQ);

    // Requester side
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [1:0]                     rsp_resp;

    // Engine side
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic                           cmd_write;
    logic [ADDR_W-1:0]              cmd_addr;
    logic [LEN_W-1:0]               cmd_len;
    logic [ID_W-1:0]                cmd_id;
    logic                           done_valid;
    logic [1:0]                     done_resp;

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        output req_ready, rsp_valid, rsp_resp,
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        input  cmd_ready, done_valid, done_resp
    );

    modport master (
        output req_valid, req_write, req_addr, req_len,
        input  req_ready, rsp_valid, rsp_resp,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        output cmd_ready, done_valid, done_resp
    );

endinterface

// File: rtl/axi_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i        : request vector
//   last_grant_i : index granted most recently; search starts one above it
//   grant_o      : one-hot grant
//   idx_o        : binary index of the grant
//   any_o        : at least one request present
module rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        logic [N-1:0] rot;
        int unsigned  cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        rot     = '0;
        cand    = 0;
        // Walk last_grant+1 .. last_grant+N (mod N); the first hit wins.
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (i + 32'(last_grant_i)) % N;
            rot  = req_i >> cand;
            if (!any_o && rot[0]) begin
                any_o = 1'b1;
                idx_o = IW'(cand);
            end
        end
        if (any_o) begin
            grant_o = N'(1) << idx_o;
        end
    end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Shares one AXI burst engine between NUM_REQ requesters.
// Picks a requester round-robin, rejects bursts crossing a 4 KB boundary
// with SLVERR, forwards accepted commands to the engine, waits for the
// engine's completion and returns its response to the granted requester.
//   aclk, areset  : clock, asynchronous active-high reset
//   bus           : requester and engine handshakes (slave modport)
//   busy          : FSM not in IDLE
//   spurious_done : sticky, done_valid seen outside WAIT
module axi_cmd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             aclk,
    input  logic             areset,
    axi_cmd_arbiter_if.slave bus,
    output logic             busy,
    output logic             spurious_done
);

    localparam int unsigned ID_W = id_width(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         resp_q, resp_d;
    logic               spurious_q, spurious_d;

    logic [NUM_REQ-1:0] rr_grant;
    logic [ID_W-1:0]    rr_idx;
    logic               rr_any;

    logic [13:0]        end_sum;
    logic               cross_4k;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .idx_o        (rr_idx),
        .any_o        (rr_any)
    );

    // Byte offset just past the last beat, relative to the 4 KB page.
    always_comb begin
        end_sum  = 14'({1'b0, bus.req_addr[rr_idx][11:0]})
                 + (14'(bus.req_len[rr_idx]) + 14'd1) * 14'(BEAT_BYTES);
        cross_4k = end_sum > 14'(BOUNDARY_BYTES);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            resp_q       <= RESP_OKAY;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            resp_q       <= resp_d;
            spurious_q   <= spurious_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        write_d       = write_q;
        addr_d        = addr_q;
        len_d         = len_q;
        resp_d        = resp_q;
        spurious_d    = spurious_q | (bus.done_valid && (state_q != WAIT));
        bus.req_ready = '0;
        bus.cmd_valid = 1'b0;
        bus.rsp_valid = '0;
        bus.rsp_resp  = RESP_OKAY;

        unique case (state_q)
            IDLE: begin
                // Gated by areset so no acceptance pulse is shown while reset is held.
                if (rr_any && !areset) begin
                    bus.req_ready = rr_grant;
                    write_d       = bus.req_write[rr_idx];
                    addr_d        = bus.req_addr[rr_idx];
                    len_d         = bus.req_len[rr_idx];
                    id_d          = rr_idx;
                    if (cross_4k) begin
                        resp_d  = RESP_SLVERR;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                bus.cmd_valid = 1'b1;
                if (bus.cmd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.done_valid) begin
                    resp_d  = bus.done_resp;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = NUM_REQ'(1) << id_q;
                bus.rsp_resp  = resp_q;
                last_grant_d  = id_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_write  = write_q;
    assign bus.cmd_addr   = addr_q;
    assign bus.cmd_len    = len_q;
    assign bus.cmd_id     = id_q;
    assign busy           = (state_q != IDLE);
    assign spurious_done  = spurious_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Self-checking bench for axi_cmd_arbiter: scoreboard of expected engine
// commands and requester responses, with a configurable engine model.
module tb_axi_cmd_arbiter;
    import axi_arb_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 8;

    logic aclk = 1'b0;
    logic areset;
    logic busy;
    logic spurious_done;

    axi_cmd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW)) bus ();

    axi_cmd_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .LEN_W   (LW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .bus           (bus),
        .busy          (busy),
        .spurious_done (spurious_done)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        logic [1:0]    id;
    } cmd_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   grant_log[$];
    int   acc_log[$];

    int   cyc = 0;
    int   acc_cyc, cmd_cyc, rsp_cyc;
    int   cmd_valid_cnt = 0;
    int   rsp_cnt = 0;
    int   model_lg = NR - 1;
    bit   in_wait = 0;
    int   wait_id = 0;
    logic prev_cmd_valid = 1'b0;

    // Engine model knobs
    int         ready_lat = 0;
    int         done_lat  = 0;
    bit         eng_hold  = 0;
    logic [1:0] next_resp = RESP_OKAY;
    bit         spur_req  = 0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge aclk) begin
        int   g, e, cand, endb;
        cmd_t c;
        rsp_t r;
        cyc++;
        if (areset) begin
            cmd_q.delete();
            rsp_q.delete();
            in_wait        = 0;
            model_lg       = NR - 1;
            prev_cmd_valid = 1'b0;
        end else begin
            if (bus.req_ready != '0) begin
                check_eq("req_ready_onehot", $onehot(bus.req_ready), 1);
                g = 0;
                for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g = i;
                e = -1;
                for (int k = 1; k <= NR; k++) begin
                    cand = (model_lg + k) % NR;
                    if (e < 0 && bus.req_valid[cand]) e = cand;
                end
                check_eq("grant", g, e);
                acc_cyc = cyc;
                grant_log.push_back(g);
                acc_log.push_back(cyc);
                endb = int'(bus.req_addr[g][11:0]) + (int'(bus.req_len[g]) + 1) * 4;
                if (endb > 4096)
                    rsp_q.push_back('{id: 2'(g), resp: RESP_SLVERR});
                else
                    cmd_q.push_back('{w: bus.req_write[g], a: bus.req_addr[g], l: bus.req_len[g], id: 2'(g)});
            end
            if (bus.done_valid && in_wait) begin
                rsp_q.push_back('{id: 2'(wait_id), resp: bus.done_resp});
                in_wait = 0;
            end
            if (bus.cmd_valid) begin
                cmd_valid_cnt++;
                if (!prev_cmd_valid) cmd_cyc = cyc;
            end
            prev_cmd_valid = bus.cmd_valid;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    check_eq("cmd_unexpected", bus.cmd_valid, 0);
                end else begin
                    c = cmd_q.pop_front();
                    check_eq("cmd_write", bus.cmd_write, c.w);
                    check_eq("cmd_addr", bus.cmd_addr, c.a);
                    check_eq("cmd_len", bus.cmd_len, c.l);
                    check_eq("cmd_id", bus.cmd_id, c.id);
                    wait_id = c.id;
                    in_wait = 1;
                end
            end
            if (bus.rsp_valid != '0) begin
                check_eq("rsp_onehot", $onehot(bus.rsp_valid), 1);
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    r = rsp_q.pop_front();
                    check_eq("rsp_id", bus.rsp_valid, 2'b01 << r.id);
                    check_eq("rsp_resp", bus.rsp_resp, r.resp);
                    model_lg = r.id;
                end
                rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
    end

    // ---------------- engine model ----------------
    initial begin : engine
        bit eng_busy;
        int cnt;
        eng_busy = 0;
        cnt = 0;
        bus.cmd_ready  = 1'b0;
        bus.done_valid = 1'b0;
        bus.done_resp  = RESP_OKAY;
        forever begin
            @(posedge aclk);
            #1;
            bus.cmd_ready  = 1'b0;
            bus.done_valid = 1'b0;
            if (areset) begin
                eng_busy = 0;
                cnt = 0;
            end else if (spur_req && !eng_busy) begin
                bus.done_valid = 1'b1;
                bus.done_resp  = RESP_OKAY;
                spur_req = 0;
            end else if (!eng_busy) begin
                if (bus.cmd_valid && !eng_hold) begin
                    if (cnt >= ready_lat) begin
                        bus.cmd_ready = 1'b1;
                        eng_busy = 1;
                        cnt = 0;
                    end else cnt++;
                end
            end else begin
                if (cnt >= done_lat) begin
                    bus.done_valid = 1'b1;
                    bus.done_resp  = next_resp;
                    eng_busy = 0;
                    cnt = 0;
                end else cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int i, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l, input string tag);
        int k;
        bit ok;
        @(posedge aclk);
        #1;
        bus.req_valid[i] = 1'b1;
        bus.req_write[i] = w;
        bus.req_addr[i]  = a;
        bus.req_len[i]   = l;
        ok = 0;
        for (k = 0; k < 100 && !ok; k++) begin
            @(negedge aclk);
            if (bus.req_ready[i]) ok = 1;
        end
        check_eq({"accept_", tag}, ok, 1);
        @(posedge aclk);
        #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int k;
        k = 0;
        while (rsp_cnt < target && k < 200) begin
            @(posedge aclk);
            k++;
        end
        check_eq({"rsp_arrived_", tag}, rsp_cnt >= target, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_req_ready"}, bus.req_ready, 0);
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({tag, "_rsp_resp"}, bus.rsp_resp, 0);
        check_eq({tag, "_cmd_valid"}, bus.cmd_valid, 0);
        check_eq({tag, "_cmd_write"}, bus.cmd_write, 0);
        check_eq({tag, "_cmd_addr"}, bus.cmd_addr, 0);
        check_eq({tag, "_cmd_len"}, bus.cmd_len, 0);
        check_eq({tag, "_cmd_id"}, bus.cmd_id, 0);
        check_eq({tag, "_spurious"}, spurious_done, 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int base, vcnt, k;
        areset        = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        repeat (3) @(negedge aclk);
        check_outputs_zero("reset");
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Fairness: both requesters held, immediate engine
        ready_lat = 0;
        done_lat  = 0;
        next_resp = RESP_OKAY;
        grant_log.delete();
        acc_log.delete();
        @(posedge aclk);
        #1;
        bus.req_valid = 2'b11;
        bus.req_addr[0] = 32'h1000;
        bus.req_addr[1] = 32'h2000;
        bus.req_len[0]  = 8'd1;
        bus.req_len[1]  = 8'd2;
        k = 0;
        while (grant_log.size() < 4 && k < 100) begin
            @(posedge aclk);
            k++;
        end
        #1;
        bus.req_valid = '0;
        check_eq("fair_count", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            check_eq("fair_g0", grant_log[0], 0);
            check_eq("fair_g1", grant_log[1], 1);
            check_eq("fair_g2", grant_log[2], 0);
            check_eq("fair_g3", grant_log[3], 1);
            check_eq("fair_period", acc_log[1] - acc_log[0], 4);
        end
        wait_rsp(4, "fair");

        // Single read with delayed engine
        ready_lat = 1;
        done_lat  = 3;
        base = rsp_cnt;
        send(0, 1'b0, 32'h4, 8'd3, "single");
        wait_rsp(base + 1, "single");
        check_eq("single_cmd_lat", cmd_cyc - acc_cyc, 1);
        check_eq("single_rsp_lat", rsp_cyc - acc_cyc, 7);

        // 4 KB reject
        ready_lat = 0;
        done_lat  = 0;
        vcnt = cmd_valid_cnt;
        base = rsp_cnt;
        send(0, 1'b1, 32'hFF8, 8'd3, "reject");
        wait_rsp(base + 1, "reject");
        check_eq("reject_rsp_lat", rsp_cyc - acc_cyc, 1);
        check_eq("reject_no_cmd", cmd_valid_cnt, vcnt);

        // 4 KB exact end is legal; engine returns DECERR which must pass through
        next_resp = 2'b11;
        vcnt = cmd_valid_cnt;
        base = rsp_cnt;
        send(1, 1'b1, 32'hFF0, 8'd3, "edge");
        wait_rsp(base + 1, "edge");
        check_eq("edge_cmd_seen", cmd_valid_cnt > vcnt, 1);
        next_resp = RESP_OKAY;

        // Engine backpressure with a second requester pending
        eng_hold = 1;
        base = rsp_cnt;
        send(0, 1'b0, 32'h100, 8'd7, "bp0");
        bus.req_valid[1] = 1'b1;
        bus.req_write[1] = 1'b1;
        bus.req_addr[1]  = 32'h200;
        bus.req_len[1]   = 8'd1;
        for (int n = 0; n < 10; n++) begin
            @(negedge aclk);
            check_eq("bp_cmd_valid", bus.cmd_valid, 1);
            check_eq("bp_cmd_addr", bus.cmd_addr, 32'h100);
            check_eq("bp_cmd_len", bus.cmd_len, 8'd7);
            check_eq("bp_cmd_write", bus.cmd_write, 0);
            check_eq("bp_req_ready1", bus.req_ready[1], 0);
            check_eq("bp_busy", busy, 1);
        end
        @(posedge aclk);
        #1;
        eng_hold = 0;
        k = 0;
        while (!bus.req_ready[1] && k < 100) begin
            @(negedge aclk);
            k++;
        end
        check_eq("bp_req1_accept", bus.req_ready[1], 1);
        @(posedge aclk);
        #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(base + 2, "bp");

        // Spurious done in IDLE
        check_eq("spur_clear_before", spurious_done, 0);
        base = rsp_cnt;
        spur_req = 1;
        repeat (3) @(negedge aclk);
        check_eq("spur_set", spurious_done, 1);
        check_eq("spur_no_rsp", rsp_cnt, base);
        send(1, 1'b0, 32'h300, 8'd0, "post_spur");
        wait_rsp(base + 1, "post_spur");
        check_eq("spur_sticky", spurious_done, 1);

        // Reset during WAIT
        done_lat = 20;
        base = rsp_cnt;
        send(1, 1'b0, 32'h40, 8'd0, "midwait");
        k = 0;
        while (!in_wait && k < 50) begin
            @(posedge aclk);
            k++;
        end
        check_eq("midwait_reached", in_wait, 1);
        #3;
        areset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(negedge aclk);
        @(posedge aclk);
        #1;
        areset   = 1'b0;
        done_lat = 0;
        repeat (25) @(negedge aclk);
        check_eq("midwait_no_rsp", rsp_cnt, base);
        grant_log.delete();
        @(posedge aclk);
        #1;
        bus.req_valid = 2'b11;
        bus.req_addr[0] = 32'h500;
        bus.req_addr[1] = 32'h600;
        bus.req_len[0]  = 8'd0;
        bus.req_len[1]  = 8'd0;
        k = 0;
        while (grant_log.size() < 1 && k < 100) begin
            @(posedge aclk);
            k++;
        end
        #1;
        bus.req_valid[0] = 1'b0;
        check_eq("post_reset_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        k = 0;
        while (grant_log.size() < 2 && k < 100) begin
            @(posedge aclk);
            k++;
        end
        #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp(base + 2, "post_reset");

        repeat (5) @(negedge aclk);
        check_eq("sb_cmd_empty", cmd_q.size(), 0);
        check_eq("sb_rsp_empty", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
